// File: rtl/pp_pipeline_accel_resize_linebuf_ring.sv
// -----------------------------------------------------------------------------
// pp_pipeline_accel_resize_linebuf_ring
//
// Ring of NumLines line buffers feeding a vertical resize stage. Pixels are
// appended one per cycle into the slot being filled; each completed line
// becomes readable. A reader fetches the same column from two vertically
// adjacent completed lines at once (rd_off and rd_off+1, counted from the
// oldest completed line). With EdgeClamp set, asking for the last completed
// line returns it on both outputs, replicating the bottom edge. pop_line
// retires the oldest completed line, which frees its slot for new writes.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high
//   sof          start of frame: synchronous clear of pointers and counts
//   in_data      pixel to append            in_valid  pixel present
//   in_ready     a pixel is accepted this cycle when in_valid is high
//   pop_line     retire the oldest completed line
//   rd_en        read request; rd_col = column, rd_off = line offset
//   rd_data0     pixel of line rd_off       (registered, 1-cycle latency)
//   rd_data1     pixel of line rd_off+1, or of line rd_off when clamped
//   rd_valid     rd_data0/1 were loaded by the previous cycle's request
//   lines_avail  number of completed, unretired lines
// -----------------------------------------------------------------------------
module pp_pipeline_accel_resize_linebuf_ring #(
  parameter int DataWidth    = 24,
  parameter int LineWidth    = 3840,
  parameter int AddressWidth = 12,
  parameter int NumLines     = 3,
  parameter int LineIdxWidth = 2,
  parameter int EdgeClamp    = 1,
  localparam int CntWidth    = $clog2(NumLines + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sof,
  input  logic [DataWidth-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    pop_line,
  input  logic                    rd_en,
  input  logic [AddressWidth-1:0] rd_col,
  input  logic [LineIdxWidth-1:0] rd_off,
  output logic [DataWidth-1:0]    rd_data0,
  output logic [DataWidth-1:0]    rd_data1,
  output logic                    rd_valid,
  output logic [CntWidth-1:0]     lines_avail
);

  localparam int MemDepth     = NumLines * LineWidth;
  localparam int MemAddrWidth = $clog2(MemDepth);
  // One spare bit so rd_off and rd_off+1 compare against lines_avail safely.
  localparam int CmpWidth     = ((LineIdxWidth > CntWidth) ? LineIdxWidth : CntWidth) + 1;

  localparam logic [AddressWidth-1:0] LastCol   = AddressWidth'(LineWidth - 1);
  localparam logic [LineIdxWidth-1:0] LastSlot  = LineIdxWidth'(NumLines - 1);
  localparam logic [CntWidth-1:0]     FullCount = CntWidth'(NumLines);
  localparam logic [LineIdxWidth:0]   NumSlots  = (LineIdxWidth + 1)'(NumLines);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // (base + off) mod NumLines. base < NumLines and off <= NumLines, so the sum
  // is below 2*NumLines and one conditional subtraction is enough.
  function automatic logic [LineIdxWidth-1:0] slot_add(
    input logic [LineIdxWidth-1:0] base,
    input logic [LineIdxWidth:0]   off
  );
    logic [LineIdxWidth:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= NumSlots) sum = sum - NumSlots;
    return sum[LineIdxWidth-1:0];
  endfunction

  function automatic logic [LineIdxWidth-1:0] slot_inc(input logic [LineIdxWidth-1:0] slot);
    return (slot == LastSlot) ? '0 : slot + 1'b1;
  endfunction

  // Flat RAM address: slot-major, column-minor.
  function automatic logic [MemAddrWidth-1:0] mem_addr(
    input logic [LineIdxWidth-1:0] slot,
    input logic [AddressWidth-1:0] col
  );
    return MemAddrWidth'(slot) * MemAddrWidth'(LineWidth) + MemAddrWidth'(col);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [AddressWidth-1:0] wcol_q,        wcol_d;
  logic [LineIdxWidth-1:0] wr_slot_q,     wr_slot_d;
  logic [LineIdxWidth-1:0] rd_base_q,     rd_base_d;
  logic [CntWidth-1:0]     lines_avail_q, lines_avail_d;
  logic                    rd_valid_q,    rd_valid_d;
  logic [DataWidth-1:0]    rd_data0_q,    rd_data1_q;

  logic [DataWidth-1:0] mem [MemDepth];

  // ---------------------------------------------------------------------------
  // Handshake and request decode (all from registered state)
  // ---------------------------------------------------------------------------
  logic                    wr_fire;
  logic                    line_done;
  logic                    pop_fire;
  logic                    rd_accept;
  logic                    rd_clamp;
  logic [CmpWidth-1:0]     off_ext;
  logic [CmpWidth-1:0]     avail_ext;
  logic [LineIdxWidth-1:0] rd_slot0;
  logic [LineIdxWidth-1:0] rd_slot1;

  assign in_ready  = (lines_avail_q < FullCount);
  assign wr_fire   = in_valid && in_ready;
  assign line_done = wr_fire && (wcol_q == LastCol);
  assign pop_fire  = pop_line && (lines_avail_q != '0);

  assign off_ext   = CmpWidth'(rd_off);
  assign avail_ext = CmpWidth'(lines_avail_q);
  // The line being filled is never counted in lines_avail, so an accepted read
  // can never address the slot currently being written.
  assign rd_clamp  = (off_ext + CmpWidth'(1)) == avail_ext;
  assign rd_accept = rd_en && (off_ext < avail_ext)
                     && ((EdgeClamp != 0) || ((off_ext + CmpWidth'(1)) < avail_ext));

  assign rd_slot0  = slot_add(rd_base_q, {1'b0, rd_off});
  assign rd_slot1  = rd_clamp ? rd_slot0
                              : slot_add(rd_base_q, {1'b0, rd_off} + 1'b1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets its default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    wcol_d        = wcol_q;
    wr_slot_d     = wr_slot_q;
    rd_base_d     = rd_base_q;
    lines_avail_d = lines_avail_q;
    rd_valid_d    = rd_accept;

    if (wr_fire) begin
      wcol_d = line_done ? '0 : wcol_q + 1'b1;
    end
    if (line_done) begin
      wr_slot_d = slot_inc(wr_slot_q);
    end
    if (pop_fire) begin
      rd_base_d = slot_inc(rd_base_q);
    end

    // Completion and retirement in the same cycle cancel out in the count.
    unique case ({line_done, pop_fire})
      2'b10:   lines_avail_d = lines_avail_q + 1'b1;
      2'b01:   lines_avail_d = lines_avail_q - 1'b1;
      default: lines_avail_d = lines_avail_q;
    endcase

    // Start of frame wins over every same-cycle write, pop and read.
    if (sof) begin
      wcol_d        = '0;
      wr_slot_d     = '0;
      rd_base_d     = '0;
      lines_avail_d = '0;
      rd_valid_d    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcol_q        <= '0;
      wr_slot_q     <= '0;
      rd_base_q     <= '0;
      lines_avail_q <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      wcol_q        <= wcol_d;
      wr_slot_q     <= wr_slot_d;
      rd_base_q     <= rd_base_d;
      lines_avail_q <= lines_avail_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Line storage: one write port, two read ports
  // ---------------------------------------------------------------------------
  // NOTE: the RAM array has no reset; clearing it would prevent RAM inference,
  // and stale contents are never visible because only completed lines are
  // readable.
  always_ff @(posedge clk) begin
    if (wr_fire && !sof) begin
      mem[mem_addr(wr_slot_q, wcol_q)] <= in_data;
    end
  end

  // Read registers hold their value on rejected or absent requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data0_q <= '0;
      rd_data1_q <= '0;
    end else if (rd_accept && !sof) begin
      rd_data0_q <= mem[mem_addr(rd_slot0, rd_col)];
      rd_data1_q <= mem[mem_addr(rd_slot1, rd_col)];
    end
  end

  assign rd_data0    = rd_data0_q;
  assign rd_data1    = rd_data1_q;
  assign rd_valid    = rd_valid_q;
  assign lines_avail = lines_avail_q;

endmodule
